// File: rtl/multiplier_nbit_pipe.sv
// ---------------------------------------------------------------------------
// multiplier_nbit_pipe
//
// Pipelined unsigned N x N multiplier built from half-width limbs. The four
// limb partial products are formed in stage 1. The two cross terms are summed
// in stage 2. The final product is recombined in stage 3. All three stages
// advance together under a single enable, so throughput is one product per
// cycle and a stalled output freezes the whole pipe.
//
// Ports
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   in_valid   M/Q carry an operand pair this cycle
//   in_ready   pair is accepted this cycle (low during reset and stalls)
//   M, Q       N-bit unsigned operands
//   out_valid  R holds a valid product
//   out_ready  downstream consumes R this cycle
//   R          2N-bit exact product M*Q
// ---------------------------------------------------------------------------
module multiplier_nbit_pipe #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   M,
    input  logic [N-1:0]   Q,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] R
);

    localparam int H = N / 2;

    // Odd or degenerate widths cannot be split into two equal limbs.
    generate
        if ((N < 2) || ((N % 2) != 0)) begin : g_bad_width
            $error("multiplier_nbit_pipe: N must be even and >= 2");
        end
    endgenerate

    // Half-width limb product, zero-extended operands give an exact N-bit result.
    function automatic logic [N-1:0] limb_mul(input logic [H-1:0] a, input logic [H-1:0] b);
        return {{H{1'b0}}, a} * {{H{1'b0}}, b};
    endfunction

    // Recombination at 2N+1 bits; the product of two N-bit values always fits
    // in 2N bits, so the extra MSB is always 0.
    function automatic logic [2*N:0] recombine(input logic [N-1:0] hh,
                                                input logic [N:0]   mid,
                                                input logic [N-1:0] ll);
        logic [2*N:0] hh_w;
        logic [2*N:0] mid_w;
        logic [2*N:0] ll_w;
        hh_w  = {{(N+1){1'b0}}, hh} << N;
        mid_w = {{N{1'b0}}, mid} << H;
        ll_w  = {{(N+1){1'b0}}, ll};
        return hh_w + mid_w + ll_w;
    endfunction

    logic           adv;
    logic           vld_p1;
    logic [N-1:0]   pp_ll_p1;
    logic [N-1:0]   pp_lh_p1;
    logic [N-1:0]   pp_hl_p1;
    logic [N-1:0]   pp_hh_p1;
    logic           vld_p2;
    logic [N:0]     mid_p2;
    logic [N-1:0]   ll_p2;
    logic [N-1:0]   hh_p2;
    logic [2*N:0]   sum_p2;
    logic           sum_msb_unused;

    // The pipe moves only when the output slot is empty or being drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = rstn && adv;

    assign sum_p2         = recombine(hh_p2, mid_p2, ll_p2);
    assign sum_msb_unused = sum_p2[2*N];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1    <= 1'b0;
            pp_ll_p1  <= '0;
            pp_lh_p1  <= '0;
            pp_hl_p1  <= '0;
            pp_hh_p1  <= '0;
            vld_p2    <= 1'b0;
            mid_p2    <= '0;
            ll_p2     <= '0;
            hh_p2     <= '0;
            out_valid <= 1'b0;
            R         <= '0;
        end else if (adv) begin
            // Stage 1: limb partial products (in_valid=0 injects a bubble)
            vld_p1   <= in_valid;
            pp_ll_p1 <= limb_mul(M[H-1:0], Q[H-1:0]);
            pp_lh_p1 <= limb_mul(M[H-1:0], Q[N-1:H]);
            pp_hl_p1 <= limb_mul(M[N-1:H], Q[H-1:0]);
            pp_hh_p1 <= limb_mul(M[N-1:H], Q[N-1:H]);

            // Stage 2: cross-term sum with carry kept
            vld_p2 <= vld_p1;
            mid_p2 <= {1'b0, pp_lh_p1} + {1'b0, pp_hl_p1};
            ll_p2  <= pp_ll_p1;
            hh_p2  <= pp_hh_p1;

            // Stage 3: final recombination
            out_valid <= vld_p2;
            R         <= sum_p2[2*N-1:0];
        end
    end

endmodule

// File: tb/tb_multiplier_nbit_pipe.sv
module tb_multiplier_nbit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        iv6, ir6, ov6, or6;
    logic [5:0]  m6, q6;
    logic [11:0] r6;

    logic        iv16, ir16, ov16, or16;
    logic [15:0] m16, q16;
    logic [31:0] r16;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q[$];

    multiplier_nbit_pipe #(.N(6)) u6 (
        .clk(clk), .rstn(rstn),
        .in_valid(iv6), .in_ready(ir6), .M(m6), .Q(q6),
        .out_valid(ov6), .out_ready(or6), .R(r6)
    );

    multiplier_nbit_pipe #(.N(16)) u16 (
        .clk(clk), .rstn(rstn),
        .in_valid(iv16), .in_ready(ir16), .M(m16), .Q(q16),
        .out_valid(ov16), .out_ready(or16), .R(r16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive6(input logic iv, input logic [5:0] m, input logic [5:0] q, input logic orr);
        iv6 = iv;
        m6  = m;
        q6  = q;
        or6 = orr;
        #1;
    endtask

    int pm[4] = '{5, 63, 0, 36};
    int pq[4] = '{7, 1, 42, 36};
    int pr[4] = '{35, 63, 0, 1296};
    int bm[3] = '{10, 20, 30};

    initial begin
        int          accepted;
        int          cycles;
        logic        prev_stall;
        logic [31:0] prev_r;

        rstn = 1'b0;
        iv6 = 1'b0; m6 = '0; q6 = '0; or6 = 1'b1;
        iv16 = 1'b0; m16 = '0; q16 = '0; or16 = 1'b1;

        // Reset state
        tick;
        tick;
        chk("rst_out_valid", ov6, 0);
        chk("rst_r", r6, 0);
        chk("rst_in_ready", ir6, 0);
        chk("rst_out_valid16", ov16, 0);
        rstn = 1'b1;

        // Test 1: single pair, out_valid in the third cycle after the accept cycle
        drive6(1, 63, 63, 1);
        chk("t1_in_ready", ir6, 1);
        tick;
        chk("t1_lat1", ov6, 0);
        drive6(0, 0, 0, 1);
        tick;
        chk("t1_lat2", ov6, 0);
        tick;
        chk("t1_valid", ov6, 1);
        chk("t1_r", r6, 3969);
        tick;
        chk("t1_valid_drop", ov6, 0);

        // Test 2: back-to-back stream
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive6(1, 6'(pm[i]), 6'(pq[i]), 1);
            else       drive6(0, 0, 0, 1);
            chk("t2_in_ready", ir6, 1);
            tick;
            if (i >= 2 && i <= 5) begin
                chk("t2_valid", ov6, 1);
                chk("t2_r", r6, 64'(pr[i-2]));
            end else begin
                chk("t2_idle", ov6, 0);
            end
        end

        // Test 3: backpressure hold then drain
        for (int i = 0; i < 3; i++) begin
            drive6(1, 6'(bm[i]), 6'(bm[i]), 1);
            tick;
        end
        chk("t3_first_valid", ov6, 1);
        chk("t3_first_r", r6, 100);
        for (int i = 0; i < 4; i++) begin
            drive6(0, 0, 0, 0);
            chk("t3_hold_in_ready", ir6, 0);
            tick;
            chk("t3_hold_valid", ov6, 1);
            chk("t3_hold_r", r6, 100);
        end
        drive6(0, 0, 0, 1);
        chk("t3_release_in_ready", ir6, 1);
        tick;
        chk("t3_second_valid", ov6, 1);
        chk("t3_second_r", r6, 400);
        tick;
        chk("t3_third_valid", ov6, 1);
        chk("t3_third_r", r6, 900);
        tick;
        chk("t3_empty", ov6, 0);

        // Test 4: bubble between two pairs
        drive6(1, 3, 4, 1);
        tick;
        drive6(0, 0, 0, 1);
        tick;
        drive6(1, 2, 9, 1);
        tick;
        chk("t4_a_valid", ov6, 1);
        chk("t4_a_r", r6, 12);
        drive6(0, 0, 0, 1);
        tick;
        chk("t4_bubble", ov6, 0);
        tick;
        chk("t4_b_valid", ov6, 1);
        chk("t4_b_r", r6, 18);
        tick;
        chk("t4_empty", ov6, 0);

        // Test 5: reset discards in-flight pairs
        drive6(1, 50, 50, 1);
        tick;
        drive6(1, 60, 60, 1);
        tick;
        drive6(0, 0, 0, 1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_in_ready", ir6, 0);
        tick;
        rstn = 1'b1;
        chk("t5_rst_valid", ov6, 0);
        chk("t5_rst_r", r6, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t5_no_ghost", ov6, 0);
        end
        drive6(1, 1, 1, 1);
        tick;
        drive6(0, 0, 0, 1);
        tick;
        tick;
        chk("t5_after_valid", ov6, 1);
        chk("t5_after_r", r6, 1);

        // Test 6: N=16 corner case
        iv16 = 1'b1; m16 = 16'hFFFF; q16 = 16'hFFFF; or16 = 1'b1;
        #1;
        tick;
        iv16 = 1'b0;
        tick;
        tick;
        chk("t6_max_valid", ov16, 1);
        chk("t6_max_r", r16, 64'd4294836225);
        tick;
        chk("t6_max_empty", ov16, 0);

        // Test 6: random traffic against a queue of expected products
        accepted   = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_r     = '0;
        while (accepted < 10000 && cycles < 60000) begin
            iv16 = ($urandom_range(0, 3) != 0);
            m16  = 16'($urandom);
            q16  = 16'($urandom);
            or16 = ($urandom_range(0, 9) < 7);
            #1;
            if (prev_stall) begin
                chk("t6_stall_valid", ov16, 1);
                chk("t6_stall_r", r16, prev_r);
            end
            chk("t6_in_ready", ir16, !ov16 || or16);
            if (ov16 && or16) begin
                if (exp_q.size() == 0) chk("t6_spurious_out", ov16, 0);
                else                   chk("t6_product", r16, exp_q.pop_front());
            end
            if (iv16 && ir16) begin
                exp_q.push_back(64'(m16) * 64'(q16));
                accepted++;
            end
            prev_stall = ov16 && !or16;
            prev_r     = r16;
            tick;
            cycles++;
        end
        chk("t6_accepted", accepted, 10000);

        // Drain remaining products
        iv16 = 1'b0;
        or16 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ov16) begin
                if (exp_q.size() == 0) chk("t6_drain_spurious", ov16, 0);
                else                   chk("t6_drain_product", r16, exp_q.pop_front());
            end
            tick;
        end
        chk("t6_drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
